// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: imem request/response, decode output, next-PC strobe and status.
// master = fetch unit, slave = memory/decode/commit environment.
interface ifu_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_rsp_valid;
  logic [DATA_WIDTH-1:0] imem_rsp_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic [DATA_WIDTH-1:0] out_inst;
  logic                  dnpc_valid;
  logic [ADDR_WIDTH-1:0] dnpc;
  logic [31:0]           fetch_cnt;
  logic                  fetch_err;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst, fetch_cnt, fetch_err,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready, dnpc_valid, dnpc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst, fetch_cnt, fetch_err,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready, dnpc_valid, dnpc
  );
endinterface

// File: rtl/ifu_fetch.sv
// Non-pipelined instruction fetch unit: REQ -> RSP -> OUT -> NPC, one instruction in flight.
// IFU_MISALIGN_CHECK_EN: misaligned dnpc traps into a sticky error state instead of being aligned.
//
// state | meaning
// S_REQ | issue imem read at pc
// S_RSP | wait for imem response
// S_OUT | present {pc, inst} to decode
// S_NPC | wait for next PC from commit
// S_ERR | misaligned next PC seen, halted until reset (macro only)
module ifu_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input logic         clk,
  input logic         rst,
  ifu_fetch_if.master bus
);

  localparam logic [2:0] S_REQ = 3'd0;
  localparam logic [2:0] S_RSP = 3'd1;
  localparam logic [2:0] S_OUT = 3'd2;
  localparam logic [2:0] S_NPC = 3'd3;
`ifdef IFU_MISALIGN_CHECK_EN
  localparam logic [2:0] S_ERR = 3'd4;
`endif

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [31:0]           cnt_q, cnt_d;
`ifdef IFU_MISALIGN_CHECK_EN
  logic                  err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
`ifdef IFU_MISALIGN_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_REQ: if (bus.imem_req_ready) state_d = S_RSP;
      S_RSP: begin
        if (bus.imem_rsp_valid) begin
          inst_d  = bus.imem_rsp_data;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          cnt_d   = cnt_q + 32'd1;
          state_d = S_NPC;
        end
      end
      S_NPC: begin
        if (bus.dnpc_valid) begin
`ifdef IFU_MISALIGN_CHECK_EN
          // faulting dnpc leaves pc untouched so the trap address is the last good one
          if (bus.dnpc[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            pc_d    = bus.dnpc;
            state_d = S_REQ;
          end
`else
          pc_d    = bus.dnpc & ~ADDR_WIDTH'(3);
          state_d = S_REQ;
`endif
        end
      end
`ifdef IFU_MISALIGN_CHECK_EN
      S_ERR:   state_d = S_ERR;
`endif
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      cnt_q   <= '0;
`ifdef IFU_MISALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
`ifdef IFU_MISALIGN_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // valids are gated by rst so nothing is offered while reset is held
  assign bus.imem_req_valid = rst && (state_q == S_REQ);
  assign bus.imem_req_addr  = pc_q;
  assign bus.out_valid      = rst && (state_q == S_OUT);
  assign bus.out_pc         = pc_q;
  assign bus.out_inst       = inst_q;
  assign bus.fetch_cnt      = cnt_q;
`ifdef IFU_MISALIGN_CHECK_EN
  assign bus.fetch_err      = err_q;
`else
  assign bus.fetch_err      = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed vector table, then randomized handshakes
// checked against a transaction-level model of the fetch protocol.
module tb_ifu_fetch;
  localparam int          AW     = 32;
  localparam int          DW     = 32;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] EBRK   = 32'h0010_0073;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ifu_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ifu_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rdy, input logic rspv, input logic [31:0] rdata,
                       input logic ordy, input logic dv, input logic [31:0] npc);
    rst                = r;
    bus.imem_req_ready = rdy;
    bus.imem_rsp_valid = rspv;
    bus.imem_rsp_data  = rdata;
    bus.out_ready      = ordy;
    bus.dnpc_valid     = dv;
    bus.dnpc           = npc;
  endtask

  typedef struct {
    logic        rst, rdy, rspv;
    logic [31:0] rdata;
    logic        ordy, dv;
    logic [31:0] npc;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_inst, e_cnt;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic rdy, input logic rspv, input logic [31:0] rdata,
                     input logic ordy, input logic dv, input logic [31:0] npc,
                     input logic e_rv, input logic [31:0] e_addr, input logic e_ov,
                     input logic [31:0] e_inst, input logic [31:0] e_cnt, input logic e_err);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.rspv = rspv; v.rdata = rdata; v.ordy = ordy; v.dv = dv; v.npc = npc;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_ov = e_ov; v.e_inst = e_inst; v.e_cnt = e_cnt;
    v.e_err = e_err;
    tbl.push_back(v);
  endtask

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // random-phase protocol model
  bit          pend, eout, anpc;
  int          dly;
  int          n_out;
  logic [31:0] epc, ecnt, raddr;

  initial begin
    logic        rdy, rspv, ordy, dv;
    logic [31:0] rdata, npc;

    drive(0, 0, 0, 0, 0, 0, 0);

    //   rst rdy rspv rdata         ordy dv npc            | rv addr          ov inst          cnt err
    add(0, 0, 0, 32'h0,          0, 0, 32'h0,           0, RST_PC,        0, 32'h0,         0, 0);
    for (int i = 0; i < 5; i++)
      add(1, 0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0,          1, RST_PC,        0, 32'h0,         0, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,           0, RST_PC,        0, 32'h0,         0, 0);
    add(1, 0, 1, EBRK,           0, 0, 32'h0,           0, RST_PC,        1, EBRK,          0, 0);
    for (int i = 0; i < 3; i++)
      add(1, 0, 0, 32'h0,        0, 1, 32'h8000_0100,   0, RST_PC,        1, EBRK,          0, 0);
    add(1, 0, 0, 32'h0,          1, 0, 32'h0,           0, RST_PC,        0, EBRK,          1, 0);
    add(1, 0, 1, 32'hCAFE_F00D,  0, 0, 32'h0,           0, RST_PC,        0, EBRK,          1, 0);
    add(1, 0, 0, 32'h0,          0, 1, 32'h8000_0010,   1, 32'h8000_0010, 0, EBRK,          1, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,           0, 32'h8000_0010, 0, EBRK,          1, 0);
    add(1, 0, 0, 32'h0,          0, 1, 32'h8000_0100,   0, 32'h8000_0010, 0, EBRK,          1, 0);
    add(1, 0, 1, 32'h1234_5678,  0, 0, 32'h0,           0, 32'h8000_0010, 1, 32'h1234_5678, 1, 0);
    add(1, 0, 0, 32'h0,          1, 0, 32'h0,           0, 32'h8000_0010, 0, 32'h1234_5678, 2, 0);
`ifdef IFU_MISALIGN_CHECK_EN
    add(1, 0, 0, 32'h0,          0, 1, 32'h8000_0006,   0, 32'h8000_0010, 0, 32'h1234_5678, 2, 1);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,           0, 32'h8000_0010, 0, 32'h1234_5678, 2, 1);
    add(1, 1, 1, 32'h0,          1, 1, 32'h8000_0000,   0, 32'h8000_0010, 0, 32'h1234_5678, 2, 1);
`else
    add(1, 0, 0, 32'h0,          0, 1, 32'h8000_0006,   1, 32'h8000_0004, 0, 32'h1234_5678, 2, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,           0, 32'h8000_0004, 0, 32'h1234_5678, 2, 0);
`endif
    add(0, 0, 0, 32'h0,          0, 0, 32'h0,           0, RST_PC,        0, 32'h0,         0, 0);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,           0, RST_PC,        0, 32'h0,         0, 0);
    add(1, 0, 1, EBRK,           0, 0, 32'h0,           0, RST_PC,        1, EBRK,          0, 0);
    add(1, 0, 0, 32'h0,          1, 0, 32'h0,           0, RST_PC,        0, EBRK,          1, 0);
    add(1, 0, 0, 32'h0,          0, 1, 32'h8000_0008,   1, 32'h8000_0008, 0, EBRK,          1, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].rdy, tbl[i].rspv, tbl[i].rdata, tbl[i].ordy, tbl[i].dv, tbl[i].npc);
      @(posedge clk);
      #1;
      check($sformatf("v%0d req_valid", i), 32'(bus.imem_req_valid), 32'(tbl[i].e_rv));
      check($sformatf("v%0d req_addr", i),  bus.imem_req_addr,        tbl[i].e_addr);
      check($sformatf("v%0d out_valid", i), 32'(bus.out_valid),      32'(tbl[i].e_ov));
      check($sformatf("v%0d out_pc", i),    bus.out_pc,               tbl[i].e_addr);
      check($sformatf("v%0d out_inst", i),  bus.out_inst,             tbl[i].e_inst);
      check($sformatf("v%0d fetch_cnt", i), bus.fetch_cnt,            tbl[i].e_cnt);
      check($sformatf("v%0d fetch_err", i), 32'(bus.fetch_err),      32'(tbl[i].e_err));
    end

    // randomized run from a fresh reset
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0);
    pend = 0; eout = 0; anpc = 0; dly = 0; n_out = 0;
    epc = RST_PC; ecnt = 0; raddr = 0;

    repeat (3000) begin
      @(negedge clk);
      check("rnd req_valid", 32'(bus.imem_req_valid), 32'(!pend && !eout && !anpc));
      if (bus.imem_req_valid) check("rnd req_addr", bus.imem_req_addr, epc);
      check("rnd out_valid", 32'(bus.out_valid), 32'(eout));
      if (bus.out_valid) begin
        check("rnd out_pc", bus.out_pc, epc);
        check("rnd out_inst", bus.out_inst, memw(epc));
      end
      check("rnd fetch_cnt", bus.fetch_cnt, ecnt);
      check("rnd fetch_err", 32'(bus.fetch_err), 32'(0));

      rdy = 1'($urandom_range(0, 1));
      if (pend) begin
        rspv  = (dly == 0);
        rdata = (dly == 0) ? memw(raddr) : $urandom;
        if (dly > 0) dly--;
      end else begin
        rspv  = ($urandom_range(0, 9) < 3);
        rdata = $urandom;
      end
      ordy = 1'($urandom_range(0, 1));
      dv   = ($urandom_range(0, 9) < 4);
      npc  = epc + 32'(4 * $urandom_range(0, 15));
`ifndef IFU_MISALIGN_CHECK_EN
      npc  = npc | 32'($urandom_range(0, 3));
`endif
      drive(1, rdy, rspv, rdata, ordy, dv, npc);

      if (!pend && !eout && !anpc) begin
        if (rdy) begin
          pend  = 1;
          raddr = epc;
          dly   = $urandom_range(0, 3);
        end
      end else if (pend) begin
        if (rspv) begin
          pend = 0;
          eout = 1;
        end
      end else if (eout) begin
        if (ordy) begin
          eout = 0;
          anpc = 1;
          ecnt = ecnt + 1;
          n_out++;
        end
      end else if (dv) begin
        anpc = 0;
        epc  = {npc[31:2], 2'b00};
      end
    end
    check("rnd progress", 32'(n_out > 100), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
